exe_stage: RTL and testbench
============================

EXE_STAGE -- requirements
Module: exe_stage

Interface
REQ-001 SHALL have parameters: DW, default 32, datapath width; IW, default 32, instruction width; RFW, default 5, register-address width.
REQ-002 SHALL have ports, one per line:
  clk  in  1  single clock; all state changes on rising edge
  start  in  1  asynchronous, active-high reset
  in_valid  in  1  ID/EXE buffer holds a valid instruction
  in_ready  out  1  stage accepts an instruction this cycle
  in_inst  in  IW  instruction from ID/EXE buffer
  r1  in  DW  operand A (register file port 1)
  r2  in  DW  operand B (register file port 2)
  imm  in  DW  sign-extended immediate from decode
  out_valid  out  1  result register holds a valid result
  out_ready  in  1  downstream (EXE/MEM buffer) consumes result
  out_result  out  DW  ALU result
  out_rd  out  RFW  destination register, in_inst[25:21]
  out_we  out  1  register-file write enable for the result
  out_inst  out  IW  instruction passed through with its result
  busy  out  1  multi-cycle multiply in progress

Function
REQ-003 Opcode SHALL be in_inst[IW-1:IW-6]: NOP 000000, ADD 000001, SUB 000010, AND 000011, OR 000100, XOR 000101, SLL 000110, SRL 000111, SLT 001000, ADDI 001001, MUL 001010.
REQ-004 Transfer in SHALL occur on a rising edge where in_valid && in_ready; transfer out where out_valid && out_ready.
REQ-005 in_ready SHALL equal (state==IDLE) && (!out_valid || out_ready), combinationally.
REQ-006 Single-cycle ops SHALL load out_result/out_rd/out_inst/out_we and set out_valid on the accepting edge (latency 1).
REQ-007 out_valid SHALL clear on an edge with out_ready && no new result loaded; output registers SHALL hold unchanged while out_valid && !out_ready.
REQ-008 Arithmetic SHALL wrap modulo 2^DW; no overflow flag.
REQ-009 SLL/SRL SHALL shift r1 by r2[4:0] (logical); SLT SHALL yield 1 if signed r1 < signed r2, else 0.
REQ-010 ADDI SHALL compute r1 + imm; all others use r2 as operand B.
REQ-011 out_we SHALL be 1 for all ops except NOP and undefined opcodes, and SHALL be forced 0 when out_rd==0.
REQ-012 Undefined opcodes SHALL behave as NOP: out_result=0, out_we=0, out_valid still asserted.
REQ-013 FSM states SHALL be IDLE, MUL, HOLD.
REQ-014 IDLE->MUL on accepting MUL: latch r1 as multiplicand, r2 as multiplier, accumulator=0, counter=0; busy=1.
REQ-015 MUL SHALL perform one shift-add iteration per cycle (add multiplicand if multiplier LSB=1; shift multiplicand left, multiplier right) for DW iterations; result is low DW bits of product.
REQ-016 After the DW-th iteration the product SHALL load the output register with out_valid=1 on edge DW+1 after accept (33 for DW=32), then go to IDLE; if out_valid && !out_ready at that point, go to HOLD and load on the first edge with out_ready, then IDLE.
REQ-017 busy SHALL be 1 in MUL and HOLD, 0 in IDLE; in_ready SHALL be 0 while busy.
REQ-018 Edges with in_valid=0 SHALL load nothing; no instruction SHALL be dropped or duplicated.

Reset
REQ-019 start=1 SHALL immediately force state=IDLE, out_valid=0, out_we=0, busy=0, out_result=0, out_rd=0, out_inst=0, counter and multiply registers=0, independent of clk.
REQ-020 start asserted mid-MUL SHALL abort the multiply with no result produced; first accept after release SHALL behave normally.

Verification
REQ-021 ADD r1=0xFFFFFFFF, r2=1, rd=3, out_ready=1 -> next edge out_valid=1, out_result=0x00000000, out_we=1, out_rd=3.
REQ-022 SLT r1=0xFFFFFFFE (-2), r2=1 -> out_result=1; SRL r1=0x80000000, r2=0x21 -> out_result=0x40000000.
REQ-023 MUL r1=0x00010001, r2=0x00000003 -> busy=1, in_ready=0 for 32 cycles; out_result=0x00030003 on edge 33 after accept; busy=0 after.
REQ-024 ADD to rd=0 -> out_we=0; undefined opcode 111111 -> out_valid=1, out_result=0, out_we=0.
REQ-025 Back-to-back ADDs with out_ready=0 for 3 cycles -> in_ready=0 during stall, out_result stable; release -> second result follows the first, none lost.
REQ-026 start pulsed at cycle 10 of a MUL -> out_valid=0, busy=0 immediately; no result emitted; subsequent ADD completes in 1 cycle.

Source files
------------

// File: rtl/exe_stage.sv
// exe_stage: single-issue ALU execute stage with valid/ready handshake and shift-add multiplier
module exe_stage #(
  parameter int DW = 32,
  parameter int IW = 32,
  parameter int RFW = 5
) (
  input  logic          clk,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [IW-1:0] in_inst,
  input  logic [DW-1:0] r1,
  input  logic [DW-1:0] r2,
  input  logic [DW-1:0] imm,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_result,
  output logic [RFW-1:0] out_rd,
  output logic          out_we,
  output logic [IW-1:0] out_inst,
  output logic          busy
);
  localparam logic [1:0] IDLE = 2'd0, MUL = 2'd1, HOLD = 2'd2;
  localparam logic [5:0] OP_ADD = 6'd1, OP_SUB = 6'd2, OP_AND = 6'd3, OP_OR = 6'd4,
                         OP_XOR = 6'd5, OP_SLL = 6'd6, OP_SRL = 6'd7, OP_SLT = 6'd8,
                         OP_ADDI = 6'd9, OP_MUL = 6'd10;
  localparam int CW = $clog2(DW + 1);
  logic [1:0] state;
  logic [DW-1:0] mcand, mplier, acc, alu;
  logic [CW-1:0] cnt;
  logic [IW-1:0] mul_inst;
  logic [5:0] op;
  logic [RFW-1:0] rd, mul_rd;
  logic alu_we, accept, drain, mul_done;
  assign op = in_inst[IW-1 -: 6];
  assign rd = in_inst[21 +: RFW];
  assign mul_rd = mul_inst[21 +: RFW];
  assign drain = !out_valid || out_ready;
  assign in_ready = (state == IDLE) && drain;
  assign accept = in_valid && in_ready;
  assign busy = state != IDLE;
  assign mul_done = (state == HOLD) || (state == MUL && cnt == CW'(DW));
  always_comb begin
    alu = '0;
    alu_we = 1'b1;
    case (op)
      OP_ADD:  alu = r1 + r2;
      OP_SUB:  alu = r1 - r2;
      OP_AND:  alu = r1 & r2;
      OP_OR:   alu = r1 | r2;
      OP_XOR:  alu = r1 ^ r2;
      OP_SLL:  alu = r1 << r2[4:0];
      OP_SRL:  alu = r1 >> r2[4:0];
      OP_SLT:  alu = {{(DW-1){1'b0}}, $signed(r1) < $signed(r2)};
      OP_ADDI: alu = r1 + imm;
      default: alu_we = 1'b0;
    endcase
  end
  always_ff @(posedge clk or posedge start) begin
    if (start) begin
      state <= IDLE;
      out_valid <= 1'b0;
      out_result <= '0;
      out_rd <= '0;
      out_we <= 1'b0;
      out_inst <= '0;
      mcand <= '0;
      mplier <= '0;
      acc <= '0;
      cnt <= '0;
      mul_inst <= '0;
    end else begin
      if (accept && op != OP_MUL) begin
        out_valid <= 1'b1;
        out_result <= alu;
        out_rd <= rd;
        out_we <= alu_we && rd != '0;
        out_inst <= in_inst;
      end else if (mul_done && drain) begin
        out_valid <= 1'b1;
        out_result <= acc;
        out_rd <= mul_rd;
        out_we <= mul_rd != '0;
        out_inst <= mul_inst;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      // one shift-add step per cycle; the product is published on the cycle after the last step
      if (accept && op == OP_MUL) begin
        state <= MUL;
        mcand <= r1;
        mplier <= r2;
        acc <= '0;
        cnt <= '0;
        mul_inst <= in_inst;
      end else if (state == MUL && cnt != CW'(DW)) begin
        acc <= mplier[0] ? acc + mcand : acc;
        mcand <= mcand << 1;
        mplier <= mplier >> 1;
        cnt <= cnt + CW'(1);
      end else if (mul_done) begin
        state <= drain ? IDLE : HOLD;
      end
    end
  end
endmodule

// File: tb/tb_exe_stage.sv
// tb_exe_stage: directed and randomized checks of exe_stage against an arithmetic reference model
module tb_exe_stage;
  logic clk = 1'b0, start, in_valid, in_ready, out_valid, out_ready, out_we, busy;
  logic [31:0] in_inst, r1, r2, imm, out_result, out_inst;
  logic [4:0] out_rd;
  int checks = 0, passed = 0, fails = 0;

  typedef struct packed {
    logic [31:0] res;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] inst;
  } exp_t;
  exp_t q[$];

  exe_stage dut (
    .clk(clk), .start(start), .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
    .r1(r1), .r2(r2), .imm(imm), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_rd(out_rd), .out_we(out_we), .out_inst(out_inst), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rd, input logic [20:0] lo);
    return {op, rd, lo};
  endfunction

  function automatic exp_t model(input logic [31:0] inst, input logic [31:0] a, input logic [31:0] b, input logic [31:0] i);
    exp_t e;
    int op;
    op = int'(inst[31:26]);
    case (op)
      1: e.res = a + b;
      2: e.res = a - b;
      3: e.res = a & b;
      4: e.res = a | b;
      5: e.res = a ^ b;
      6: e.res = a << b[4:0];
      7: e.res = a >> b[4:0];
      8: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      9: e.res = a + i;
      10: e.res = a * b;
      default: e.res = 32'd0;
    endcase
    e.rd = inst[25:21];
    e.we = (op >= 1 && op <= 10) && inst[25:21] != 5'd0;
    e.inst = inst;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] a, input logic [31:0] b);
    in_valid = v;
    in_inst = inst;
    r1 = a;
    r2 = b;
    imm = 32'h0;
  endtask

  // scoreboarded cycle: compare a departing result, record an accepted instruction, advance
  task automatic sb_cycle();
    exp_t e;
    #1;
    if (out_valid && out_ready) begin
      if (q.size() == 0) chk("sb_unexpected_out", 64'(0), 64'(1));
      else begin
        e = q.pop_front();
        chk("sb_result", 64'(out_result), 64'(e.res));
        chk("sb_we", 64'(out_we), 64'(e.we));
        chk("sb_rd", 64'(out_rd), 64'(e.rd));
        chk("sb_inst", 64'(out_inst), 64'(e.inst));
      end
    end
    if (in_valid && in_ready) q.push_back(model(in_inst, r1, r2, imm));
    tick();
  endtask

  initial begin
    int lat, bad, n, r;
    logic [5:0] op;
    start = 1'b1;
    out_ready = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_out_result", 64'(out_result), 64'(0));
    chk("rst_out_we", 64'(out_we), 64'(0));
    chk("rst_out_rd", 64'(out_rd), 64'(0));
    chk("rst_out_inst", 64'(out_inst), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    start = 1'b0;
    tick();

    drive(1'b1, mk(6'd1, 5'd3, 21'h0), 32'hFFFF_FFFF, 32'h1);
    tick();
    chk("add_wrap_valid", 64'(out_valid), 64'(1));
    chk("add_wrap_result", 64'(out_result), 64'(0));
    chk("add_wrap_we", 64'(out_we), 64'(1));
    chk("add_wrap_rd", 64'(out_rd), 64'(3));
    drive(1'b1, mk(6'd8, 5'd4, 21'h0), 32'hFFFF_FFFE, 32'h1);
    tick();
    chk("slt_neg", 64'(out_result), 64'(1));
    drive(1'b1, mk(6'd7, 5'd5, 21'h0), 32'h8000_0000, 32'h21);
    tick();
    chk("srl_mask", 64'(out_result), 64'h4000_0000);
    drive(1'b1, mk(6'd1, 5'd0, 21'h0), 32'd5, 32'd6);
    tick();
    chk("rd0_valid", 64'(out_valid), 64'(1));
    chk("rd0_we", 64'(out_we), 64'(0));
    drive(1'b1, mk(6'b111111, 5'd9, 21'h0), 32'd5, 32'd6);
    tick();
    chk("undef_valid", 64'(out_valid), 64'(1));
    chk("undef_result", 64'(out_result), 64'(0));
    chk("undef_we", 64'(out_we), 64'(0));
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    tick();
    chk("idle_drain", 64'(out_valid), 64'(0));

    drive(1'b1, mk(6'd10, 5'd7, 21'h0), 32'h0001_0001, 32'h3);
    tick();
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    lat = 0;
    bad = 0;
    while (!out_valid && lat < 100) begin
      if (!busy || in_ready) bad++;
      tick();
      lat++;
    end
    chk("mul_latency", 64'(lat), 64'(33));
    chk("mul_busy_window", 64'(bad), 64'(0));
    chk("mul_result", 64'(out_result), 64'h0003_0003);
    chk("mul_we", 64'(out_we), 64'(1));
    chk("mul_busy_after", 64'(busy), 64'(0));
    tick();

    out_ready = 1'b0;
    drive(1'b1, mk(6'd1, 5'd1, 21'h0), 32'd5, 32'd6);
    tick();
    chk("stall_first", 64'(out_result), 64'(11));
    drive(1'b1, mk(6'd1, 5'd2, 21'h0), 32'd7, 32'd8);
    bad = 0;
    repeat (3) begin
      if (in_ready || out_result !== 32'd11 || !out_valid) bad++;
      tick();
    end
    chk("stall_hold", 64'(bad), 64'(0));
    out_ready = 1'b1;
    #1;
    chk("stall_release_ready", 64'(in_ready), 64'(1));
    tick();
    chk("stall_second_result", 64'(out_result), 64'(15));
    chk("stall_second_rd", 64'(out_rd), 64'(2));
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    tick();
    chk("stall_drained", 64'(out_valid), 64'(0));

    drive(1'b1, mk(6'd10, 5'd6, 21'h0), 32'd1234, 32'd5678);
    tick();
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    repeat (9) tick();
    start = 1'b1;
    #1;
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_valid", 64'(out_valid), 64'(0));
    start = 1'b0;
    n = 0;
    repeat (40) begin
      tick();
      if (out_valid) n++;
    end
    chk("abort_no_result", 64'(n), 64'(0));
    drive(1'b1, mk(6'd1, 5'd4, 21'h0), 32'd2, 32'd3);
    tick();
    chk("post_abort_add", 64'(out_result), 64'(5));
    chk("post_abort_valid", 64'(out_valid), 64'(1));
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    tick();

    repeat (600) begin
      r = int'($urandom_range(0, 99));
      op = r < 3 ? 6'd10 : r < 90 ? 6'($urandom_range(0, 9)) : 6'($urandom_range(11, 63));
      in_valid = $urandom_range(0, 9) < 6;
      in_inst = mk(op, 5'($urandom_range(0, 31)), 21'($urandom));
      r1 = $urandom;
      r2 = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 40));
      imm = $urandom;
      out_ready = $urandom_range(0, 3) != 0;
      sb_cycle();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      sb_cycle();
      n++;
    end
    chk("sb_drained", 64'(q.size()), 64'(0));
    chk("sb_final_valid", 64'(out_valid), 64'(0));
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
